pipe_seq_ctrl: RTL

PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_seq_ctrl_sat_cnt16.sv | 21 ++
 rtl/pipe_seq_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-sequencer types: scoreboard entry layout and segment indices.
package pipe_pkg;

  localparam int RAW_MAX = 16;
  localparam int SEG_IF  = 0;
  localparam int SEG_ID  = 1;

  // rd is sized for the widest supported register address; narrower
  // addresses are zero-extended on entry.
  typedef struct packed {
    logic               valid;
    logic [RAW_MAX-1:0] rd;
    logic               we;
    logic               load;
  } sb_entry_t;

  function automatic int seg_wb(input int nstage);
    return nstage - 1;
  endfunction

endpackage

// File: rtl/pipe_seq_ctrl_sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  output logic [15:0] o_cnt
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// In-order pipeline sequencer: RAW-hazard stall, taken-branch flush, per-segment enables.
// Define PIPE_FWD_EN for forwarding builds, where only load-use in segment 2 stalls.
module pipe_seq_ctrl
  import pipe_pkg::*;
#(
  parameter int NSTAGE   = 5,
  parameter int RAW      = 5,
  parameter int BR_STAGE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [RAW-1:0]    id_rs,
  input  logic [RAW-1:0]    id_rt,
  input  logic              id_rs_use,
  input  logic              id_rt_use,
  input  logic [RAW-1:0]    id_rd,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              br_taken,
  output logic [NSTAGE-1:0] stage_en,
  output logic [NSTAGE-1:0] stage_valid,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  localparam int WB    = seg_wb(NSTAGE);
  localparam int HZ_LO = 2;
`ifdef PIPE_FWD_EN
  localparam int HZ_HI     = 2;
  localparam bit LOAD_ONLY = 1'b1;
`else
  localparam int HZ_HI     = NSTAGE - 2;
  localparam bit LOAD_ONLY = 1'b0;
`endif

  logic      r_vld0;
  logic      r_vld1;
  sb_entry_t r_sb  [2:WB];

  sb_entry_t         w_sb1;
  sb_entry_t         w_nsb [2:WB];
  logic              w_nvld0;
  logic              w_nvld1;
  logic              w_hazard;
  logic              w_flush;
  logic              w_stall;
  logic              w_flush_ev;
  logic [NSTAGE-1:0] w_valid;
  logic [RAW_MAX-1:0] w_rs;
  logic [RAW_MAX-1:0] w_rt;

  function automatic logic src_hit(input logic en, input logic [RAW_MAX-1:0] src,
                                   input sb_entry_t e);
    return en && (src != '0) && e.valid && e.we && (src == e.rd);
  endfunction

  // Segment 1 is described live by the decode inputs; only its valid is held here.
  assign w_sb1 = '{valid: r_vld1, rd: RAW_MAX'(id_rd), we: id_we, load: id_load};
  assign w_rs  = RAW_MAX'(id_rs);
  assign w_rt  = RAW_MAX'(id_rt);

  always_comb begin
    w_valid    = '0;
    w_valid[0] = r_vld0;
    w_valid[1] = r_vld1;
    for (int k = 2; k <= WB; k++) w_valid[k] = r_sb[k].valid;
  end

  // The writeback segment is never checked: the register file writes before it reads.
  always_comb begin
    w_hazard = 1'b0;
    for (int k = HZ_LO; k <= HZ_HI; k++) begin
      if (!LOAD_ONLY || r_sb[k].load) begin
        w_hazard = w_hazard | src_hit(id_rs_use, w_rs, r_sb[k])
                            | src_hit(id_rt_use, w_rt, r_sb[k]);
      end
    end
    w_hazard = w_hazard & r_vld1;
  end

  assign w_flush    = br_taken & w_valid[BR_STAGE];
  assign w_stall    = w_hazard & ~w_flush;
  assign w_flush_ev = w_flush;

  always_comb begin
    stage_en = '1;
    if (w_stall) stage_en[1:0] = 2'b00;
  end

  always_comb begin
    w_nvld0 = r_vld0;
    w_nvld1 = r_vld1;
    for (int k = 2; k <= WB; k++) w_nsb[k] = r_sb[k];
    if (w_stall) begin
      w_nsb[2] = '0;
      for (int k = 3; k <= WB; k++) w_nsb[k] = r_sb[k-1];
    end else begin
      w_nvld0  = if_valid;
      w_nvld1  = r_vld0;
      w_nsb[2] = w_sb1;
      for (int k = 3; k <= WB; k++) w_nsb[k] = r_sb[k-1];
      // Everything younger than the branch is wrong-path, including the slot it vacates.
      if (w_flush) begin
        w_nvld0 = 1'b0;
        w_nvld1 = 1'b0;
        for (int k = 2; k <= BR_STAGE; k++) w_nsb[k] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld0 <= 1'b0;
      r_vld1 <= 1'b0;
      for (int k = 2; k <= WB; k++) r_sb[k] <= '0;
    end else begin
      r_vld0 <= w_nvld0;
      r_vld1 <= w_nvld1;
      for (int k = 2; k <= WB; k++) r_sb[k] <= w_nsb[k];
    end
  end

  assign stage_valid = w_valid;

  sat_cnt16 u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (w_stall),
    .o_cnt (stall_cnt)
  );

  sat_cnt16 u_flush_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (w_flush_ev),
    .o_cnt (flush_cnt)
  );

endmodule
